logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pipe_if.sv | 40 ++++
 rtl/logic_unit_pipe.sv | 125 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe_if
// Bundles the operand-side and result-side handshakes of logic_unit_pipe.
//   slave  : the logic unit itself (consumes operands, produces results)
//   master : the surrounding datapath (operand register file / result bus)
// Signals:
//   in_valid/in_ready   operand handshake
//   a, b, op            operands and 3-bit function select
//   acc_en, acc_clr     accumulator substitute-for-a and clear
//   out_valid/out_ready result handshake
//   result, zero, parity, op_count  result word, flags, delivered count
// -----------------------------------------------------------------------------
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             parity;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, parity, op_count
  );

  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, parity, op_count
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Two-stage valid/ready pipelined bitwise function unit with an accumulator.
// Eight bitwise functions of x and b, where x is either operand a or the
// previous computed value (accumulate mode). Each result carries zero and
// parity flags; op_count counts results taken by the consumer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    logic_unit_pipe_if.slave (operand / result handshakes, flags)
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  logic_unit_pipe_if.slave       bus
);

  function automatic logic [WIDTH-1:0] logic_fn(
    input logic [2:0]       fsel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    unique case (fsel)
      3'b000:  r = x & y;
      3'b001:  r = ~(x & y);
      3'b010:  r = x | y;
      3'b011:  r = ~(x | y);
      3'b100:  r = x ^ y;
      3'b101:  r = ~(x ^ y);
      3'b110:  r = ~x;
      default: r = y;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] x_sel;
  logic [WIDTH-1:0] fn_val;
  logic             accept;
  logic             adv_p2;
  logic             take;

  logic [WIDTH-1:0] data_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] result_p2;
  logic             zero_p2;
  logic             parity_p2;
  logic             vld_p2;
  logic [CNT_W-1:0] cnt_q;

  assign x_sel  = bus.acc_en ? acc_q : bus.a;
  assign fn_val = logic_fn(bus.op, x_sel, bus.b);

  // Stage 1 frees up whenever stage 2 is empty or draining this cycle, so
  // ready depends on out_ready but never on in_valid.
  assign bus.in_ready = !vld_p1 || !vld_p2 || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign adv_p2       = vld_p1 && (!vld_p2 || bus.out_ready);
  assign take         = vld_p2 && bus.out_ready;

  // Accumulator: follows every computed value; a clear wins over the load,
  // and the operation issued alongside a clear still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (bus.acc_clr) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= fn_val;
    end
  end

  // ---- stage 1: capture ----
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= fn_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (adv_p2) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- stage 2: output ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      zero_p2   <= 1'b1;
      parity_p2 <= 1'b0;
    end else if (adv_p2) begin
      vld_p2    <= 1'b1;
      result_p2 <= data_p1;
      zero_p2   <= (data_p1 == '0);
      parity_p2 <= ^data_p1;
    end else if (take) begin
      vld_p2    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.result    = result_p2;
  assign bus.zero      = zero_p2;
  assign bus.parity    = parity_p2;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  logic clk;
  logic reset;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(8)) ifc ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2)) ifc2 ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // Narrow-counter copy fed with identical stimulus, for the wrap check.
  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.slave)
  );

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.a         = ifc.a;
  assign ifc2.b         = ifc.b;
  assign ifc2.op        = ifc.op;
  assign ifc2.acc_en    = ifc.acc_en;
  assign ifc2.acc_clr   = ifc.acc_clr;
  assign ifc2.out_ready = ifc.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       acc_en;
    logic       acc_clr;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [17];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive_idle();
    ifc.in_valid = 1'b0;
    ifc.acc_en   = 1'b0;
    ifc.acc_clr  = 1'b0;
    ifc.op       = 3'd0;
    ifc.a        = 8'h00;
    ifc.b        = 8'h00;
  endtask

  task automatic drive_vec(input vec_t v);
    ifc.in_valid = 1'b1;
    ifc.op       = v.op;
    ifc.acc_en   = v.acc_en;
    ifc.acc_clr  = v.acc_clr;
    ifc.a        = v.a;
    ifc.b        = v.b;
  endtask

  task automatic drive_pass(input logic [7:0] bv);
    ifc.in_valid = 1'b1;
    ifc.op       = 3'b111;
    ifc.acc_en   = 1'b0;
    ifc.acc_clr  = 1'b0;
    ifc.a        = 8'h00;
    ifc.b        = bv;
  endtask

  // Streams vecs[first..last] back to back with out_ready=1; each result must
  // appear exactly two cycles after its operands are presented.
  task automatic run_vectors(input int first, input int last);
    int n;
    vec_t v;
    n = last - first + 1;
    for (int c = 0; c < n + 2; c++) begin
      @(posedge clk); #1;
      if (c >= 2) begin
        v = vecs[first + c - 2];
        check($sformatf("vec%0d out_valid", first + c - 2), ifc.out_valid, 1);
        check($sformatf("vec%0d result", first + c - 2), ifc.result, v.exp);
        check($sformatf("vec%0d zero", first + c - 2), ifc.zero, (v.exp == 8'h00));
        check($sformatf("vec%0d parity", first + c - 2), ifc.parity, ^v.exp);
      end else begin
        check($sformatf("lat%0d out_valid", c), ifc.out_valid, 0);
      end
      check("op_count", ifc.op_count, exp_cnt);
      check("op_count_w2", ifc2.op_count, exp_cnt % 4);
      if (c >= 2) exp_cnt++;
      if (c < n) drive_vec(vecs[first + c]);
      else drive_idle();
      check("in_ready stream", ifc.in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] bp_vals [4];
  int idx;
  int got;

  initial begin
    // opcode sweep, a=A5 b=0F
    vecs[0]  = '{3'b000, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h05};
    vecs[1]  = '{3'b001, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hFA};
    vecs[2]  = '{3'b010, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hAF};
    vecs[3]  = '{3'b011, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h50};
    vecs[4]  = '{3'b100, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'hAA};
    vecs[5]  = '{3'b101, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h55};
    vecs[6]  = '{3'b110, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h5A};
    vecs[7]  = '{3'b111, 1'b0, 1'b0, 8'hA5, 8'h0F, 8'h0F};
    // accumulate chain, starting from a cleared accumulator
    vecs[8]  = '{3'b010, 1'b1, 1'b0, 8'h80, 8'h01, 8'h01};
    vecs[9]  = '{3'b010, 1'b1, 1'b0, 8'h80, 8'h02, 8'h03};
    vecs[10] = '{3'b010, 1'b1, 1'b0, 8'h80, 8'h04, 8'h07};
    vecs[11] = '{3'b100, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hF8};
    vecs[12] = '{3'b010, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00};
    vecs[13] = '{3'b110, 1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF};
    vecs[14] = '{3'b000, 1'b1, 1'b0, 8'h00, 8'h3C, 8'h3C};
    vecs[15] = '{3'b011, 1'b0, 1'b0, 8'h0F, 8'h30, 8'hC0};
    vecs[16] = '{3'b101, 1'b1, 1'b0, 8'h00, 8'hC3, 8'hFC};

    bp_vals[0] = 8'h11;
    bp_vals[1] = 8'h22;
    bp_vals[2] = 8'h33;
    bp_vals[3] = 8'h44;

    // Power-on reset
    reset         = 1'b1;
    ifc.out_ready = 1'b1;
    drive_idle();
    #3;
    check("rst out_valid", ifc.out_valid, 0);
    check("rst result", ifc.result, 8'h00);
    check("rst zero", ifc.zero, 1);
    check("rst parity", ifc.parity, 0);
    check("rst op_count", ifc.op_count, 0);
    check("rst in_ready", ifc.in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Opcode sweep
    run_vectors(0, 7);

    // Standalone clear pulse (accumulator holds 0F from the sweep)
    @(posedge clk); #1;
    ifc.acc_clr = 1'b1;
    @(posedge clk); #1;
    ifc.acc_clr = 1'b0;

    // Accumulate chain, clear-with-accept, mixed ops
    run_vectors(8, 16);

    // Reset in the middle of a stream
    @(posedge clk); #1;
    drive_pass(8'h5A);
    @(posedge clk); #1;
    drive_pass(8'h3C);
    @(posedge clk); #1;
    drive_idle();
    check("pre-rst out_valid", ifc.out_valid, 1);
    check("pre-rst result", ifc.result, 8'h5A);
    check("pre-rst op_count", ifc.op_count, exp_cnt);
    #2;
    reset = 1'b1;
    #1;
    check("async rst out_valid", ifc.out_valid, 0);
    check("async rst result", ifc.result, 8'h00);
    check("async rst zero", ifc.zero, 1);
    check("async rst parity", ifc.parity, 0);
    check("async rst op_count", ifc.op_count, 0);
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post-rst flushed", ifc.out_valid, 0);
    end

    // Backpressure: four operations with the consumer stalled
    ifc.out_ready = 1'b0;
    idx = 0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (idx < 4) drive_pass(bp_vals[idx]);
      else drive_idle();
      @(negedge clk);
      if (ifc.out_valid) begin
        check("bp hold result", ifc.result, 8'h11);
        check("bp hold zero", ifc.zero, 0);
        check("bp hold parity", ifc.parity, 0);
      end
      if (ifc.in_valid && ifc.in_ready) idx++;
    end
    check("bp accepts", idx, 2);
    check("bp in_ready", ifc.in_ready, 0);
    check("bp out_valid", ifc.out_valid, 1);
    check("bp op_count", ifc.op_count, 0);

    ifc.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (ifc.out_valid) begin
        if (got < 4) check($sformatf("bp result%0d", got), ifc.result, bp_vals[got]);
        else check("bp duplicate", ifc.out_valid, 0);
        got++;
      end
      if (ifc.in_valid && ifc.in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 4) drive_pass(bp_vals[idx]);
      else drive_idle();
      @(negedge clk);
    end
    check("bp delivered", got, 4);
    check("bp accepted total", idx, 4);
    check("bp op_count", ifc.op_count, 4);
    check("bp op_count_w2", ifc2.op_count, 0);

    // Counter wrap on the narrow-counter instance
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    exp_cnt = 0;
    run_vectors(0, 4);
    @(posedge clk); #1;
    check("wrap op_count", ifc.op_count, 5);
    check("wrap op_count_w2", ifc2.op_count, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
